traffic_light_controller_timed: RTL
===================================

// Module: traffic_light_controller_timed
// PURPOSE
//  Parametrised highway/country-road intersection controller. Cycle-counted phase
//  timing: min highway green, max country green, yellow, all-red clearance on both
//  sides. Adds maintenance flash mode. Drop-in for the fixed-delay controller.
//  Outputs drive lamp drivers directly.
// PARAMETERS
//  CNT_W          8  phase timer width; every delay below must satisfy 1 <= d < 2**CNT_W
//  Y2R_DELAY      3  cycles a road shows yellow before red
//  R2G_DELAY      2  all-red clearance cycles before either road turns green
//  MIN_GREEN_HWY  4  minimum highway-green cycles before a country request is honoured
//  MAX_GREEN_CTRY 8  maximum country-green cycles even if x stays high
//  FLASH_HALF     4  cycles per on/off half-period in flash mode
// PORTS
//  clk           in   1  single clock, all state on posedge
//  clear         in   1  reset, synchronous, active-high
//  x             in   1  country-road vehicle sensor (1 = car waiting/present)
//  maint         in   1  maintenance request: enter flash mode
//  highway_road  out  2  lamp code: 0 red, 1 yellow, 2 green, 3 off
//  country_road  out  2  lamp code, same encoding
//  state_o       out  3  current state encoding, debug/observation
// BEHAVIOUR
//  Reset: clear sampled at posedge -> state S0, timer 0, flash_ph 0; clear beats maint
//   and x. After reset: highway_road=2, country_road=0, state_o=0.
//  Moore outputs decoded combinationally from the state register, no extra latency.
//  timer: 0 on first cycle of every state, +1 per cycle, cleared on every transition,
//   saturates at 2**CNT_W-1 (S0, S3 can dwell indefinitely/long).
//  States (enc: hwy/ctry):
//   S0 HWY_GREEN  (0: 2/0)  -> S1 when x && timer >= MIN_GREEN_HWY-1
//   S1 HWY_YELLOW (1: 1/0)  -> S2 when timer == Y2R_DELAY-1
//   S2 ALL_RED_A  (2: 0/0)  -> S3 when timer == R2G_DELAY-1
//   S3 CTRY_GREEN (3: 0/2)  -> S4 when !x || timer == MAX_GREEN_CTRY-1
//   S4 CTRY_YELLOW(4: 0/1)  -> S5 when timer == Y2R_DELAY-1
//   S5 ALL_RED_B  (5: 0/0)  -> S0 when timer == R2G_DELAY-1
//   S6 FLASH      (6: flash_ph ? 3/3 : 1/0)
//  Hence S1, S2, S4, S5 last exactly their delay; x ignored outside S0/S3.
//  maint=1 in any state S0..S5 -> S6 next cycle (overrides phase transition);
//   timer, flash_ph cleared on entry.
//  In S6: timer counts to FLASH_HALF-1, then wraps to 0 and flash_ph toggles; so
//   highway alternates yellow/off, country red/off, FLASH_HALF cycles each, yellow first.
//  S6 with maint=0 -> S5 (all-red clearance) then S0; never directly to any green.
//  x high at reset release with MIN_GREEN_HWY=1: S0 lasts one cycle.
//  Illegal state encoding 7 -> S5 next cycle (safe all-red recovery).
//  Invariant: never green on both roads; green never follows green or yellow
//   without a full R2G_DELAY all-red.
// TESTING (defaults)
//  1 clear 2 cyc, x=0 for 30 cyc -> highway_road=2, country_road=0 every cycle.
//  2 x=1 from first post-reset cycle -> S0 4 cyc, hwy=1 3 cyc, 0/0 2 cyc,
//    country=2 from cycle 9.
//  3 x held 1 -> country green exactly 8 cyc, yellow 3, 0/0 2, then highway=2.
//  4 x drops after 2 cyc of S3 -> S4 on next edge; yellow 3 cyc, all-red 2, S0.
//  5 maint=1 in S1 -> S6 next cyc; hwy 1,1,1,1,3,3,3,3,1..; ctry 0x4,3x4;
//    maint=0 -> 0/0 2 cyc, then 2/0.
//  6 clear=1 with maint=1 while in S3 -> next edge state_o=0, 2/0; force state 7 -> S5.

Source files
------------

// File: rtl/traffic_light_controller_timed.sv
`default_nettype none
// ============================================================================
// Module  : traffic_light_controller_timed
// Brief   : Highway/country intersection controller with cycle-counted phases
//           and a maintenance flash mode.
// Revision: 1.0 - initial release
// ============================================================================
module traffic_light_controller_timed #(
    parameter int CNT_W          = 8,
    parameter int Y2R_DELAY      = 3,
    parameter int R2G_DELAY      = 2,
    parameter int MIN_GREEN_HWY  = 4,
    parameter int MAX_GREEN_CTRY = 8,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       maint,
    output logic [1:0] highway_road,
    output logic [1:0] country_road,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S0_HWY_GREEN   = 3'd0,
        S1_HWY_YELLOW  = 3'd1,
        S2_ALL_RED_A   = 3'd2,
        S3_CTRY_GREEN  = 3'd3,
        S4_CTRY_YELLOW = 3'd4,
        S5_ALL_RED_B   = 3'd5,
        S6_FLASH       = 3'd6
    } state_t;

    localparam logic [1:0] c_red    = 2'd0;
    localparam logic [1:0] c_yellow = 2'd1;
    localparam logic [1:0] c_green  = 2'd2;
    localparam logic [1:0] c_off    = 2'd3;

    localparam logic [CNT_W-1:0] c_min_hwy  = CNT_W'(MIN_GREEN_HWY - 1);
    localparam logic [CNT_W-1:0] c_y2r      = CNT_W'(Y2R_DELAY - 1);
    localparam logic [CNT_W-1:0] c_r2g      = CNT_W'(R2G_DELAY - 1);
    localparam logic [CNT_W-1:0] c_max_ctry = CNT_W'(MAX_GREEN_CTRY - 1);
    localparam logic [CNT_W-1:0] c_flash    = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] c_tmr_max  = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_flash_ph;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= S0_HWY_GREEN;
            r_timer    <= '0;
            r_flash_ph <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_timer    <= '0;
                r_flash_ph <= 1'b0;
            end else if (r_state == S6_FLASH) begin
                // Flash half-period: wrap the timer and swap lamp phase.
                if (r_timer == c_flash) begin
                    r_timer    <= '0;
                    r_flash_ph <= ~r_flash_ph;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else if (r_timer != c_tmr_max) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S0_HWY_GREEN:   if (x && (r_timer >= c_min_hwy))       w_next = S1_HWY_YELLOW;
            S1_HWY_YELLOW:  if (r_timer == c_y2r)                  w_next = S2_ALL_RED_A;
            S2_ALL_RED_A:   if (r_timer == c_r2g)                  w_next = S3_CTRY_GREEN;
            S3_CTRY_GREEN:  if (!x || (r_timer == c_max_ctry))     w_next = S4_CTRY_YELLOW;
            S4_CTRY_YELLOW: if (r_timer == c_y2r)                  w_next = S5_ALL_RED_B;
            S5_ALL_RED_B:   if (r_timer == c_r2g)                  w_next = S0_HWY_GREEN;
            S6_FLASH:       if (!maint)                            w_next = S5_ALL_RED_B;
            default:                                               w_next = S5_ALL_RED_B;
        endcase
        // Maintenance wins over any phase change, but an illegal code still recovers via all-red.
        if (maint && (r_state <= S5_ALL_RED_B))
            w_next = S6_FLASH;
    end

    always_comb begin
        highway_road = c_red;
        country_road = c_red;
        case (r_state)
            S0_HWY_GREEN:   highway_road = c_green;
            S1_HWY_YELLOW:  highway_road = c_yellow;
            S3_CTRY_GREEN:  country_road = c_green;
            S4_CTRY_YELLOW: country_road = c_yellow;
            S6_FLASH: begin
                highway_road = r_flash_ph ? c_off : c_yellow;
                country_road = r_flash_ph ? c_off : c_red;
            end
            default: begin
                highway_road = c_red;
                country_road = c_red;
            end
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire
